// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed common-anode 7-segment driver.
// Double-buffered digit codes with per-digit blank and blink, plus optional leading-zero suppression.
module seg7_scan_driver #(
  parameter int NDIGITS      = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                 clk,
  input  logic                 clrn,
  input  logic                 load,
  input  logic [4*NDIGITS-1:0] data_in,
  input  logic [NDIGITS-1:0]   blank_in,
  input  logic [NDIGITS-1:0]   blink_in,
  input  logic                 lzs,
  output logic [6:0]           seg_n,
  output logic [NDIGITS-1:0]   dig_n,
  output logic                 busy,
  output logic                 frame
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NDIGITS);
  localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CLAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] ILAST = IW'(NDIGITS - 1);
  localparam logic [FW-1:0] FLAST = FW'(BLINK_FRAMES - 1);
  // Active-low g..a patterns for codes F down to 0.
  localparam logic [111:0] LUT = {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
                                  7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [FW-1:0]        fcnt;
  logic                 phase_off;
  logic [4*NDIGITS-1:0] act_data, pend_data;
  logic [NDIGITS-1:0]   act_blank, pend_blank, act_blink, pend_blink;
  logic [NDIGITS-1:0]   sup;
  logic                 tc, fb, z, dark;
  logic [3:0]           code;
  logic [6:0]           seg_next;

  assign tc = cnt == CLAST;
  assign fb = tc && idx == ILAST;

  // A digit is suppressed when it and every digit above it hold zero.
  always_comb begin
    sup = '0;
    z = 1'b1;
    for (int i = NDIGITS - 1; i >= 1; i--) begin
      z = z & (act_data[4*i +: 4] == 4'd0);
      sup[i] = lzs & z;
    end
  end

  always_comb begin
    code = act_data[4*idx +: 4];
    dark = act_blank[idx] | (act_blink[idx] & phase_off) | sup[idx];
    seg_next = dark ? 7'h7F : LUT[7*code +: 7];
  end

  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      cnt        <= '0;
      idx        <= '0;
      fcnt       <= '0;
      phase_off  <= 1'b0;
      act_data   <= '0;
      pend_data  <= '0;
      act_blank  <= '1;
      pend_blank <= '1;
      act_blink  <= '0;
      pend_blink <= '0;
      busy       <= 1'b0;
      frame      <= 1'b0;
      seg_n      <= 7'h7F;
      dig_n      <= '1;
    end else begin
      cnt   <= tc ? '0 : cnt + 1'b1;
      frame <= fb;
      if (tc) idx <= idx == ILAST ? '0 : idx + 1'b1;
      if (fb) begin
        fcnt <= fcnt == FLAST ? '0 : fcnt + 1'b1;
        if (fcnt == FLAST) phase_off <= ~phase_off;
      end
      if (load) {pend_data, pend_blank, pend_blink} <= {data_in, blank_in, blink_in};
      // A load landing on the boundary bypasses pending so it is never lost.
      if (fb && load) {act_data, act_blank, act_blink} <= {data_in, blank_in, blink_in};
      else if (fb && busy) {act_data, act_blank, act_blink} <= {pend_data, pend_blank, pend_blink};
      busy  <= !fb && (load || busy);
      seg_n <= seg_next;
      dig_n <= ~(NDIGITS'(1) << idx);
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: random and directed stimulus against a time-arithmetic reference model.
module tb_seg7_scan_driver;
  localparam int ND = 4, SD = 4, BF = 2, FR = ND * SD;
  logic        clk = 0, clrn = 0, load = 0, lzs = 0;
  logic [15:0] data_in = '0;
  logic [3:0]  blank_in = '0, blink_in = '0;
  logic [6:0]  seg_n;
  logic [3:0]  dig_n;
  logic        busy, frame;
  int          total = 0, bad = 0, k = 0;
  logic [15:0] a_dat, p_dat;
  logic [3:0]  a_blank, p_blank, a_blink, p_blink;
  logic        m_busy;
  logic [6:0]  lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg7_scan_driver #(.NDIGITS(ND), .SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .clrn(clrn), .load(load), .data_in(data_in), .blank_in(blank_in),
    .blink_in(blink_in), .lzs(lzs), .seg_n(seg_n), .dig_n(dig_n), .busy(busy), .frame(frame));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s k=%0d got=%0h exp=%0h", tag, k, got, exp);
    end
  endtask

  task automatic model_reset();
    a_dat = '0; p_dat = '0; a_blank = '1; p_blank = '1; a_blink = '0; p_blink = '0;
    m_busy = 0; k = 0;
  endtask

  // One clock: predict outputs from the digit slot and frame number implied by elapsed cycles.
  task automatic tick();
    int d;
    logic zero_up, dark, bnd, ld, phase_off;
    logic [6:0] es;
    logic [3:0] ed;
    logic [15:0] di;
    logic [3:0] bl, bk;
    d = (k / SD) % ND;
    zero_up = 1;
    for (int j = d; j < ND; j++) if (a_dat[4*j +: 4] != 0) zero_up = 0;
    phase_off = ((k / FR) / BF) % 2 == 1;
    dark = a_blank[d] || (a_blink[d] && phase_off) || (lzs && d > 0 && zero_up);
    es = dark ? 7'h7F : lut[a_dat[4*d +: 4]];
    ed = ~(4'b0001 << d);
    bnd = (k % FR) == FR - 1;
    ld = load; di = data_in; bl = blank_in; bk = blink_in;
    @(posedge clk); #1;
    if (bnd) begin
      if (ld) begin a_dat = di; a_blank = bl; a_blink = bk; end
      else if (m_busy) begin a_dat = p_dat; a_blank = p_blank; a_blink = p_blink; end
      m_busy = 0;
    end else if (ld) begin
      p_dat = di; p_blank = bl; p_blink = bk; m_busy = 1;
    end
    k++;
    check("seg", 32'(seg_n), 32'(es));
    check("dig", 32'(dig_n), 32'(ed));
    check("busy", 32'(busy), 32'(m_busy));
    check("frame", 32'(frame), 32'(bnd));
    load = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic align(input int m);
    while (k % FR != m) tick();
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] bl, input logic [3:0] bk);
    load = 1; data_in = d; blank_in = bl; blink_in = bk;
    tick();
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_seg", 32'(seg_n), 32'h7F);
      check("rst_dig", 32'(dig_n), 32'hF);
      check("rst_busy", 32'(busy), 0);
      check("rst_frame", 32'(frame), 0);
    end
    clrn = 1;
    run(40);
    align(5);
    do_load(16'h4321, 4'h0, 4'h0);
    run(40);
    align(6);
    do_load(16'h1234, 4'h0, 4'h0);
    run(3);
    do_load(16'h00A5, 4'h0, 4'h0);
    run(40);
    align(FR - 1);
    do_load(16'h0777, 4'h0, 4'h0);
    check("bnd_busy", 32'(busy), 0);
    run(34);
    lzs = 1;
    do_load(16'h0050, 4'h0, 4'h0);
    run(34);
    do_load(16'h0000, 4'h0, 4'h0);
    run(34);
    lzs = 0;
    do_load(16'h0050, 4'h0, 4'h0);
    run(34);
    do_load(16'h0008, 4'h0, 4'h1);
    run(5 * FR);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) lzs = ~lzs;
      if ($urandom_range(0, 7) == 0)
        do_load(16'($urandom), $urandom_range(0, 3) == 0 ? 4'($urandom) : 4'h0, 4'($urandom));
      else tick();
    end
    align(9);
    do_load(16'h9876, 4'h0, 4'h0);
    check("pre_rst_busy", 32'(busy), 1);
    #3 clrn = 0;
    #1;
    check("async_seg", 32'(seg_n), 32'h7F);
    check("async_dig", 32'(dig_n), 32'hF);
    check("async_busy", 32'(busy), 0);
    check("async_frame", 32'(frame), 0);
    @(posedge clk); #1;
    check("hold_dig", 32'(dig_n), 32'hF);
    clrn = 1;
    model_reset();
    run(3 * FR);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised, time-multiplexed driver for an NDIGITS common-anode 7-segment display. It holds one 4-bit hex/BCD code per digit in a double-buffered register file and scans the digits one at a time. It applies per-digit blanking, per-digit blinking and optional leading-zero suppression. It sits between any value producer (counter, calculator, keyboard lab) and the board's shared segment/digit-enable pins, and replaces per-digit combinational decoders wherever pins are multiplexed.

## Interface
Parameters:
- NDIGITS, 4: number of digits; 2..8.
- SCAN_DIV, 50000: clock cycles each digit is driven; must be ≥ 2.
- BLINK_FRAMES, 32: full scan frames per blink half-period; must be ≥ 1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- clrn  in  1  asynchronous active-low reset.
- load  in  1  single-cycle request to capture the three inputs below.
- data_in  in  4*NDIGITS  digit codes; digit i is bits [4i+3:4i]; digit 0 is least significant (rightmost).
- blank_in  in  NDIGITS  1 = digit i forced dark.
- blink_in  in  NDIGITS  1 = digit i blinks.
- lzs  in  1  leading-zero suppression enable; used live, not buffered.
- seg_n  out  7  active-low segments; bit 6 = g … bit 0 = a.
- dig_n  out  NDIGITS  active-low digit enables; at most one bit low.
- busy  out  1  a pending load has not yet reached the active buffer.
- frame  out  1  one-cycle pulse on each frame boundary.

## Operation
- **Decode (active-low, g..a):**
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
  - Blank: 7F.
- **Scan counter** cnt runs 0..SCAN_DIV-1. At terminal count, cnt → 0 and digit index idx advances 0→1→…→NDIGITS-1→0.
- **Frame boundary:** the cycle in which cnt is at terminal count and idx = NDIGITS-1. frame is registered and is high during the following cycle.
- **Double buffering:**
  - load copies data_in, blank_in and blink_in into the pending buffer and sets busy.
  - A load while busy overwrites pending; the latest load wins.
  - At a frame boundary with busy = 1, pending → active and busy clears.
  - If load coincides with a frame boundary, the load data goes directly into active and busy ends the cycle at 0.
  - The active buffer never changes mid-frame.
- **Blink:** a frame counter counts 0..BLINK_FRAMES-1 at frame boundaries. The phase bit toggles on each wrap. While phase = off, digits with an active blink bit are dark.
- **Leading-zero suppression (lzs = 1):** digit i (i ≥ 1) is dark when its active code and all higher-index codes are 0. Digit 0 is never suppressed. The blank mask does not affect this evaluation.
- **Dark rule:** a digit is dark if its blank bit is set, or it is blink-off, or it is suppressed. For a dark digit, seg_n = 7F and its dig_n bit is still asserted, so scan timing stays uniform.
- **Output register:** each cycle, seg_n and dig_n are loaded from the current idx and active buffer. dig_n has bit idx low.
- **Reset values (clrn = 0, asynchronous):**
  - Outputs: seg_n = 7F, dig_n = all ones, busy = 0, frame = 0.
  - Counters and phase: cnt = 0, idx = 0, frame counter = 0, blink phase = on.
  - Buffers: active and pending data = 0; active and pending blank = all ones; blink masks = 0.

## Timing
- Outputs lag the internal state by one cycle.
- First rising edge after clrn deasserts: dig_n selects digit 0, which is dark because the reset blank mask is all ones.
- Each digit is driven for exactly SCAN_DIV cycles. A frame is NDIGITS*SCAN_DIV cycles.
- Load-to-display latency is at most one frame plus 2 cycles. The new values appear on digit 0, in the cycle after frame pulses.
- Blink half-period is BLINK_FRAMES*NDIGITS*SCAN_DIV cycles.
- Reset asserted mid-frame: everything returns to reset values immediately, and pending loads are discarded.
- Reset deassertion needs no synchronous load.

## Test plan
(NDIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2 unless noted.)
- **Reset/scan:** hold clrn low, then release.
  - During reset: seg_n = 7F, dig_n = F, busy = 0.
  - After release: dig_n sequence is E, D, B, 7, each for 4 cycles, repeating every 16 cycles.
  - frame pulses every 16 cycles; seg_n stays 7F.
- **Load mid-frame:** load data_in = 4321, blank_in = 0, blink_in = 0 while idx = 1.
  - busy = 1 until the boundary.
  - Frame pulse, then digit 0 shows 79 (1), and subsequent digits show 24, 30, 19.
- **Load collision:** a second load of 00A5 before the boundary overwrites the first; only 00A5 is ever displayed.
  - A load on the boundary cycle leaves busy = 0 next cycle and shows the new data from the next frame.
- **Leading-zero suppression:** data 0050, lzs = 1.
  - Digits 3 and 2 show 7F, digit 1 shows 12, digit 0 shows 40.
  - Data 0000 gives 7F, 7F, 7F, 40.
  - With lzs = 0, digits 3 and 2 show 40.
- **Blink:** blink_in = 0001, data 0008, lzs = 0.
  - Digit 0 shows 00 for 2 frames, 7F for 2 frames, then repeats.
  - Other digits show 40 throughout.
- **Reset mid-operation:** assert clrn while busy = 1 at idx = 2.
  - Outputs show reset values asynchronously.
  - After release, the display stays dark and the pending data is never shown.
